// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The buffer depth depends on the FETCH_BUF_EN macro: 2 entries when it is
// defined, so fetching continues through one cycle of stall; 1 entry otherwise.
package temp;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        FETCH   = 2'b00,  // free to issue a request
        WAIT    = 2'b01,  // one request outstanding
        DISCARD = 2'b10   // outstanding response will be dropped
    } fetch_state_t;

`ifdef FETCH_BUF_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    // Byte distance between consecutive instruction words.
    localparam int PC_STEP = 4;

    // Instruction field slices handed to the control unit.
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small instruction buffer for the fetch unit: holds {pc, instruction}
// records.
// Pop and push may happen in the same cycle even when full.
// A flush empties the buffer in one cycle.
// dout reads as zero while the buffer is empty.
module fetch_fifo #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SLOTS = 2 ** PTR_W;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [0:SLOTS-1];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with wrap at the last real slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | pop);
    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == '0);
    assign dout      = empty ? '0 : mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; flush drops every held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared at reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word fetch at a time, buffers the
// responses with their addresses and presents the head to decode.
// A taken branch flushes the buffer and redirects; a response still in flight
// at that moment is dropped.
// Define FETCH_BUF_EN for a 2-entry buffer (default build: 1 entry).
module instr_fetch
    import temp::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall_in,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [6:0]      opcode_out,
    output logic [2:0]      funct3_out,
    output logic [6:0]      funct7_out
);

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] PC_INC           = XLEN'(PC_STEP);

    fetch_state_t      state_r;
    fetch_state_t      state_nx_s;
    logic [XLEN-1:0]   next_pc_r;
    logic [XLEN-1:0]   next_pc_nx_s;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   addr_nx_s;
    logic              req_r;
    logic              req_nx_s;
    logic [XLEN-1:0]   target_s;
    logic              resp_s;
    logic              room_s;
    logic              push_s;
    logic              pop_s;
    logic              flush_s;
    logic              full_s;
    logic              empty_s;
    logic [2*XLEN-1:0] fifo_din_s;
    logic [2*XLEN-1:0] fifo_dout_s;

    assign target_s   = {branch_target[XLEN-1:2], 2'b00};
    // A response is never expected in the cycle its request is on the bus;
    // this also screens out a stale strobe left over from before a reset.
    assign resp_s     = imem_valid & ~req_r;
    assign pop_s      = ~empty_s & ~stall_in & ~branch_taken;
    assign flush_s    = branch_taken;
    assign room_s     = ~full_s | pop_s;
    assign fifo_din_s = {addr_r, imem_rdata};

    // Next-state, redirect and request decisions; branch_taken wins over all.
    always_comb begin
        state_nx_s   = state_r;
        next_pc_nx_s = next_pc_r;
        addr_nx_s    = addr_r;
        req_nx_s     = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            FETCH: begin
                if (branch_taken) begin
                    next_pc_nx_s = target_s;
                end else if (room_s) begin
                    req_nx_s     = 1'b1;
                    addr_nx_s    = next_pc_r;
                    next_pc_nx_s = next_pc_r + PC_INC;
                    state_nx_s   = WAIT;
                end else begin
                    state_nx_s   = FETCH;
                end
            end
            WAIT: begin
                if (resp_s && branch_taken) begin
                    next_pc_nx_s = target_s;
                    state_nx_s   = FETCH;
                end else if (resp_s) begin
                    push_s       = 1'b1;
                    state_nx_s   = FETCH;
                end else if (branch_taken) begin
                    next_pc_nx_s = target_s;
                    state_nx_s   = DISCARD;
                end else begin
                    state_nx_s   = WAIT;
                end
            end
            DISCARD: begin
                if (branch_taken) begin
                    next_pc_nx_s = target_s;
                end else begin
                    next_pc_nx_s = next_pc_r;
                end
                if (resp_s) begin
                    state_nx_s = FETCH;
                end else begin
                    state_nx_s = DISCARD;
                end
            end
            default: begin
                state_nx_s = FETCH;
            end
        endcase
    end

    // FSM state, fetch pointer and the registered request bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= FETCH;
            next_pc_r <= RESET_PC_ALIGNED;
            addr_r    <= '0;
            req_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            next_pc_r <= next_pc_nx_s;
            addr_r    <= addr_nx_s;
            req_r     <= req_nx_s;
        end
    end

    fetch_fifo #(
        .DEPTH (FETCH_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .full  (full_s),
        .empty (empty_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s)
    );

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr_valid = ~empty_s;
    assign instr_out   = fifo_dout_s[XLEN-1:0];
    assign pc_out      = fifo_dout_s[2*XLEN-1:XLEN];
    assign opcode_out  = instr_out[OPCODE_MSB:OPCODE_LSB];
    assign funct3_out  = instr_out[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7_out  = instr_out[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed table, hand-written branch/reset
// sequences and a randomized run against a queue-based reference model.
module tb_instr_fetch;

`ifdef FETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        imem_req, imem_valid, branch_taken, stall_in, instr_valid;
    logic [31:0] imem_addr, imem_rdata, branch_target, instr_out, pc_out;
    logic [6:0]  opcode_out, funct7_out;
    logic [2:0]  funct3_out;

    logic        w_req, w_valid, w_iv;
    logic        w_branch, w_stall;
    logic [31:0] w_addr, w_rdata, w_target, w_instr, w_pc;
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    instr_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .stall_in(stall_in), .instr_valid(instr_valid), .instr_out(instr_out),
        .pc_out(pc_out), .opcode_out(opcode_out), .funct3_out(funct3_out),
        .funct7_out(funct7_out)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(w_valid), .imem_rdata(w_rdata),
        .branch_taken(w_branch), .branch_target(w_target),
        .stall_in(w_stall), .instr_valid(w_iv), .instr_out(w_instr),
        .pc_out(w_pc), .opcode_out(w_op), .funct3_out(w_f3), .funct7_out(w_f7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
        else pass_cnt++;
    endtask

    // Instruction word the bench memory returns for an address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mq[$];          // addresses the buffer should hold, head first
    logic [31:0] fetch_pc;       // address the next request must carry
    logic [31:0] resp_pc;        // address of the request in flight
    logic        outstanding;
    logic        dropped;
    int          lat_cnt;
    int          pops;
    int unsigned stall_pct, branch_pct, lat_max;

    task automatic model_reset();
        mq.delete();
        fetch_pc    = 32'h0;
        outstanding = 1'b0;
        dropped     = 1'b0;
        lat_cnt     = 0;
        pops        = 0;
    endtask

    task automatic idle();
        imem_valid = 1'b0; imem_rdata = 32'h0; branch_taken = 1'b0;
        branch_target = 32'h0; stall_in = 1'b0;
        w_valid = 1'b0; w_rdata = 32'h0; w_branch = 1'b0; w_target = 32'h0; w_stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk1({tag, "_iv"}, instr_valid, 1'b0);
        chk({tag, "_instr"}, instr_out, 32'h0);
        chk({tag, "_pc"}, pc_out, 32'h0);
        chk({tag, "_fields"}, {15'd0, opcode_out, funct3_out, funct7_out}, 32'h0);
    endtask

    task automatic do_reset();
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        chk1("reset_wrap_req", w_req, 1'b0);
        rst_n = 1'b1;
    endtask

    // One clock of model-checked operation, with bench memory and random inputs.
    task automatic cycle();
        logic        v, br, just;
        logic [31:0] tgt, w;
        tick();
        chk1("instr_valid", instr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            w = word_of(mq[0]);
            chk("pc_out", pc_out, mq[0]);
            chk("instr_out", instr_out, w);
            chk("fields", {15'd0, opcode_out, funct3_out, funct7_out},
                {15'd0, w[6:0], w[14:12], w[31:25]});
        end
        just = 1'b0;
        if (imem_req) begin
            chk1("single_outstanding", outstanding, 1'b0);
            chk1("req_room", mq.size() < DEPTH, 1'b1);
            chk("fetch_addr", imem_addr, fetch_pc);
            resp_pc     = fetch_pc;
            fetch_pc    = fetch_pc + 32'd4;
            outstanding = 1'b1;
            dropped     = 1'b0;
            lat_cnt     = int'($urandom_range(lat_max, 1));
            just        = 1'b1;
        end
        v = 1'b0;
        if (outstanding && !just) begin
            lat_cnt--;
            if (lat_cnt == 0) v = 1'b1;
        end
        br  = ($urandom_range(99, 0) < branch_pct);
        tgt = $urandom;
        imem_valid    = v;
        imem_rdata    = v ? word_of(resp_pc) : $urandom;
        stall_in      = ($urandom_range(99, 0) < stall_pct);
        branch_taken  = br;
        branch_target = tgt;
        if (br) begin
            mq.delete();
            fetch_pc = {tgt[31:2], 2'b00};
            if (outstanding && !v) dropped = 1'b1;
        end else begin
            if (mq.size() > 0 && !stall_in) begin
                void'(mq.pop_front());
                pops++;
            end
            if (v && !dropped) mq.push_back(resp_pc);
        end
        if (v) outstanding = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        valid;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] bad;
        logic        seen;
        tbl[0] = '{1'b0, 32'h0,          1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 32'h0041_8193,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b0, 32'h0,          1'b0, 32'h0, 1'b1, 32'h0, 32'h0041_8193};
        tbl[3] = '{1'b0, 32'h0,          1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 32'h4020_8033,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[5] = '{1'b0, 32'h0,          1'b0, 32'h0, 1'b1, 32'h4, 32'h4020_8033};
        tbl[6] = '{1'b0, 32'h0,          1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
        tbl[7] = '{1'b1, 32'hABCD_E0F7,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[8] = '{1'b0, 32'h0,          1'b0, 32'h0, 1'b1, 32'h8, 32'hABCD_E0F7};
        bad = 32'hBAD0_BAD0;

        idle();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");

        // Consecutive fetches with a 1-cycle memory.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick();
            chk1($sformatf("tbl%0d_req", i), imem_req, tbl[i].exp_req);
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk1($sformatf("tbl%0d_iv", i), instr_valid, tbl[i].exp_iv);
            if (tbl[i].exp_iv) begin
                chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].exp_pc);
                chk($sformatf("tbl%0d_instr", i), instr_out, tbl[i].exp_instr);
                chk($sformatf("tbl%0d_opcode", i), {25'd0, opcode_out}, {25'd0, tbl[i].exp_instr[6:0]});
            end
            imem_valid = tbl[i].valid;
            imem_rdata = tbl[i].rdata;
        end

        // Branch while waiting; stale response 3 cycles later is dropped.
        do_reset();
        tick();
        chk("br_wait_first_addr", imem_addr, 32'h0);
        tick();
        branch_taken = 1'b1; branch_target = 32'h0000_0102;
        for (int i = 0; i < 3; i++) begin
            tick();
            branch_taken = 1'b0;
            chk1("br_wait_no_iv", instr_valid, 1'b0);
            chk1("br_wait_no_req", imem_req, 1'b0);
        end
        imem_valid = 1'b1; imem_rdata = bad;
        tick();
        imem_valid = 1'b0;
        chk1("br_wait_dropped", instr_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick();
            if (imem_req) seen = 1'b1;
            else chk1("br_wait_still_empty", instr_valid, 1'b0);
        end
        chk1("br_wait_req_seen", seen, 1'b1);
        chk("br_wait_target_addr", imem_addr, 32'h0000_0100);

        // Branch coincident with the response.
        do_reset();
        tick();
        tick();
        imem_valid = 1'b1; imem_rdata = bad;
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        tick();
        imem_valid = 1'b0; branch_taken = 1'b0;
        chk1("br_coinc_no_iv", instr_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (i > 0) tick();
            if (imem_req) seen = 1'b1;
            else chk1("br_coinc_still_empty", instr_valid, 1'b0);
        end
        chk1("br_coinc_req_seen", seen, 1'b1);
        chk("br_coinc_target_addr", imem_addr, 32'h0000_0200);
        tick();
        imem_valid = 1'b1; imem_rdata = 32'h0123_4567;
        tick();
        imem_valid = 1'b0;
        chk1("br_coinc_resume_iv", instr_valid, 1'b1);
        chk("br_coinc_resume_pc", pc_out, 32'h0000_0200);
        chk("br_coinc_resume_instr", instr_out, 32'h0123_4567);

        // Address wrap from the top of memory.
        do_reset();
        tick();
        chk1("wrap_req0", w_req, 1'b1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick();
        w_valid = 1'b1; w_rdata = 32'h0000_0013;
        tick();
        w_valid = 1'b0;
        chk1("wrap_iv", w_iv, 1'b1);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        tick();
        chk1("wrap_req1", w_req, 1'b1);
        chk("wrap_addr1", w_addr, 32'h0000_0000);

        // Stall held: buffer fills to its depth, no further requests.
        do_reset();
        stall_pct = 100; branch_pct = 0; lat_max = 1;
        repeat (8) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk1("stall_no_req", imem_req, 1'b0);
            chk("stall_head_pc", pc_out, 32'h0);
        end
        stall_pct = 0;
        cycle();
        cycle();
`ifdef FETCH_BUF_EN
        chk1("stall_release_iv", instr_valid, 1'b1);
        chk("stall_release_pc", pc_out, 32'h4);
`else
        chk1("stall_release_iv", instr_valid, 1'b0);
`endif
        repeat (30) cycle();
        chk1("stall_release_progress", pops >= 5, 1'b1);

        // Reset asserted mid-request with a late response.
        do_reset();
        stall_pct = 0; branch_pct = 0; lat_max = 3;
        for (int i = 0; i < 10 && !outstanding; i++) cycle();
        chk1("midreset_req_outstanding", outstanding, 1'b1);
        imem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset_async");
        imem_valid = 1'b1; imem_rdata = bad;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        model_reset();
        cycle();
        chk1("midreset_new_req", imem_req, 1'b1);
        chk("midreset_instr_clear", instr_out, 32'h0);
        repeat (20) cycle();

        // Randomized run against the model.
        do_reset();
        stall_pct = 25; branch_pct = 5; lat_max = 3;
        repeat (3000) cycle();
        chk1("random_progress", pops > 100, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter XLEN, default 32, the address and instruction width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req, output, 1 bit: a one-cycle pulse issuing a fetch at imem_addr.
REQ-006 SHALL have port imem_addr, output, XLEN bits: fetch address, word-aligned.
REQ-007 SHALL have port imem_valid, input, 1 bit: response strobe, at least 1 cycle after imem_req.
REQ-008 SHALL have port imem_rdata, input, XLEN bits: instruction word, qualified by imem_valid.
REQ-009 SHALL have port branch_taken, input, 1 bit: redirect request from the execute stage.
REQ-010 SHALL have port branch_target, input, XLEN bits: redirect address.
REQ-011 SHALL have port stall_in, input, 1 bit: decode/control unit not ready.
REQ-012 SHALL have port instr_valid, output, 1 bit: instruction presented to decode.
REQ-013 SHALL have port instr_out, output, XLEN bits: buffer-head instruction.
REQ-014 SHALL have port pc_out, output, XLEN bits: address of instr_out.
REQ-015 SHALL have ports opcode_out (7), funct3_out (3) and funct7_out (7), outputs: instr_out[6:0], [14:12] and [31:25], driven straight into the control unit.

Function
REQ-016 SHALL implement FSM states from fetch_state_t: FETCH (may issue), WAIT (one request outstanding), DISCARD (outstanding response is to be dropped).
REQ-017 SHALL allow at most one outstanding request.
REQ-018 SHALL pulse imem_req in FETCH only when buffer occupancy < depth; otherwise it SHALL remain in FETCH with imem_req low.
REQ-019 SHALL, on an issued request, advance next_pc by 4 (wrapping 32'hFFFF_FFFC to 0) and go to WAIT.
REQ-020 SHALL, in WAIT with imem_valid, push {imem_addr of that request, imem_rdata} into the buffer and return to FETCH; the next request MAY issue in that same cycle.
REQ-021 SHALL drive instr_valid = buffer non-empty; the head SHALL pop when instr_valid && !stall_in.
REQ-022 SHALL support pop and push in the same cycle when full.
REQ-023 SHALL, on branch_taken, flush the buffer, set next_pc = {branch_target[XLEN-1:2], 2'b00}, and deassert instr_valid in the following cycle.
REQ-024 SHALL, on branch_taken in WAIT without imem_valid, go to DISCARD; the next imem_valid SHALL be dropped and the FSM SHALL return to FETCH.
REQ-025 SHALL, on branch_taken coincident with imem_valid, drop the response and go directly to FETCH.
REQ-026 SHALL give branch_taken priority over pop, push and stall_in.
REQ-027 SHALL have 1-cycle fetch-to-instr_valid latency, measured from imem_valid to instr_valid high.

Reset
REQ-028 SHALL, while rst_n is low: FSM=FETCH, next_pc=RESET_PC, buffer empty, imem_req=0, instr_valid=0; instr_out, pc_out and the decoded fields SHALL be 0.
REQ-029 SHALL, when rst_n asserts mid-request, ignore any imem_valid arriving after reset release until a new request has issued.

Configuration
REQ-030 SHALL, with FETCH_BUF_EN defined, use a 2-entry buffer so that fetch continues for one cycle of stall_in.
REQ-031 SHALL, without FETCH_BUF_EN, use a 1-entry buffer: no request issues while an entry is held unless that entry pops in the same cycle.

Structure
REQ-032 SHALL define fetch_state_t, FETCH_DEPTH and the instruction field-slice constants in package temp.
REQ-033 SHALL place the buffer in sub-module fetch_fifo, with ports push, pop, flush, full, empty, din and dout.

Verification
REQ-034 Reset release, memory with 1-cycle latency, no stall -> PCs 0, 4, 8 presented on consecutive responses; opcode_out = rdata[6:0].
REQ-035 stall_in held 5 cycles with FETCH_BUF_EN -> exactly 2 entries held, imem_req stays low, no instruction lost or duplicated after release.
REQ-036 branch_taken with target 32'h0000_0102 while WAIT, response 3 cycles later -> response dropped, next imem_addr = 32'h0000_0100.
REQ-037 branch_taken coincident with imem_valid -> rdata never appears on instr_out; next request goes to the target.
REQ-038 RESET_PC=32'hFFFF_FFFC -> second fetch address is 32'h0000_0000.
REQ-039 rst_n pulsed low while WAIT, with a late imem_valid -> outputs stay at reset values and the late data is not enqueued.
